// File: rtl/result_display_8bit.sv
// ---------------------------------------------------------------------------
// result_display_8bit
//
// Display stage for the 8-bit token calculator. A finished 8-bit unsigned
// result is captured on a load strobe and converted to three BCD digits by a
// sequential double-dabble engine (one shift per clock, 8 clocks in total).
// The last completed conversion drives a time-multiplexed, active-low
// 7-segment display, with optional leading-zero blanking.
//
// Parameters:
//   SCAN_DIV      clocks each digit is held on the display (>= 2)
//   BLANK_LEADING 1 = blank leading zeros in the hundreds and tens positions
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-low reset
//   value  in   8-bit unsigned result, sampled only on an accepted load
//   load   in   request to convert value, accepted only while idle
//   busy   out  high while a conversion is running
//   done   out  one-cycle pulse when bcd has just been updated
//   bcd    out  last completed result {hundreds, tens, units}
//   seg    out  active-low segments {g,f,e,d,c,b,a}
//   an     out  active-low digit enables (0 units, 1 tens, 2 hundreds, 3 off)
// ---------------------------------------------------------------------------
module result_display_8bit #(
  parameter int SCAN_DIV      = 16,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t           r_state;
  logic [7:0]       r_shift;
  logic [11:0]      r_scratch;
  logic [2:0]       r_iter;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_digit;

  logic [11:0]      w_adjusted;
  logic [19:0]      w_shifted;
  logic [1:0]       w_nextDigit;
  logic [3:0]       w_nibble;
  logic             w_blank;

  // Double-dabble correction: a nibble of 5 or more becomes >= 8 after +3,
  // so the following left shift carries correctly into the next decade.
  function automatic logic [3:0] fixNibble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Active-low 7-segment decode; codes 10..15 and blanked digits go dark.
  function automatic logic [6:0] segOf(input logic [3:0] n, input logic blank);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return blank ? 7'b1111111 : s;
  endfunction

  // One double-dabble iteration: correct every nibble, then shift the
  // combined {scratch, shift register} left by one. The hundreds digit never
  // exceeds 2, so the bit shifted out of the top is always zero.
  always_comb begin
    w_adjusted = {fixNibble(r_scratch[11:8]), fixNibble(r_scratch[7:4]),
                  fixNibble(r_scratch[3:0])};
    w_shifted  = {w_adjusted, r_shift} << 1;
  end

  // Converter FSM. bcd is written only when the eighth shift completes, so the
  // display never sees a partially converted value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shift   <= 8'd0;
      r_scratch <= 12'd0;
      r_iter    <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= 12'h000;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift   <= value;
            r_scratch <= 12'd0;
            r_iter    <= 3'd0;
            busy      <= 1'b1;
            r_state   <= S_CONV;
          end
        end
        S_CONV: begin
          r_scratch <= w_shifted[19:8];
          r_shift   <= w_shifted[7:0];
          r_iter    <= r_iter + 3'd1;
          if (r_iter == 3'd7) begin
            bcd     <= w_shifted[19:8];
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Select the digit that becomes visible at the next scan step, together
  // with its leading-zero blanking condition.
  always_comb begin
    w_nextDigit = 2'd0;
    w_nibble    = bcd[3:0];
    w_blank     = 1'b0;
    case (r_digit)
      2'd0: begin
        w_nextDigit = 2'd1;
        w_nibble    = bcd[7:4];
        w_blank     = BLANK_LEADING && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
      end
      2'd1: begin
        w_nextDigit = 2'd2;
        w_nibble    = bcd[11:8];
        w_blank     = BLANK_LEADING && (bcd[11:8] == 4'd0);
      end
      default: begin
        w_nextDigit = 2'd0;
        w_nibble    = bcd[3:0];
        w_blank     = 1'b0;
      end
    endcase
  end

  // Free-running scan. seg/an are reloaded only when the divider wraps, so a
  // new bcd value appears digit by digit at scan steps rather than mid-hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div   <= '0;
      r_digit <= 2'd0;
      an      <= 4'b1110;
      seg     <= 7'b1000000;
    end else if (r_div == DIV_LAST) begin
      r_div   <= '0;
      r_digit <= w_nextDigit;
      an      <= ~(4'b0001 << w_nextDigit);
      seg     <= segOf(w_nibble, w_blank);
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: tb/tb_result_display_8bit.sv
// ---------------------------------------------------------------------------
// tb_result_display_8bit
//
// Self-checking bench for result_display_8bit. Two instances share stimulus:
// dut with leading-zero blanking, dutRaw without. Expected BCD results are
// pushed to a queue when a load is driven and popped whenever done pulses.
// ---------------------------------------------------------------------------
module tb_result_display_8bit;

  localparam int SCAN_DIV = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        load  = 1'b0;
  logic [7:0]  value = 8'd0;

  logic        busy,  done;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [3:0]  an;

  logic        busy0, done0;
  logic [11:0] bcd0;
  logic [6:0]  seg0;
  logic [3:0]  an0;

  int nChecks   = 0;
  int nFails    = 0;
  int nDone     = 0;
  int nAccepted = 0;
  logic [11:0] expQ[$];
  logic [11:0] monExp;

  typedef struct {
    logic [7:0]  value;
    logic [11:0] expBcd;
  } vec_t;

  vec_t vecs[10];

  logic [6:0] segTable [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  result_display_8bit #(.SCAN_DIV(SCAN_DIV), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy), .done(done), .bcd(bcd), .seg(seg), .an(an)
  );

  result_display_8bit #(.SCAN_DIV(SCAN_DIV), .BLANK_LEADING(1'b0)) dutRaw (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy0), .done(done0), .bcd(bcd0), .seg(seg0), .an(an0)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] toBcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives a one-clock load from a falling edge; returns on the next falling
  // edge, i.e. just after the rising edge that sampled it.
  task automatic applyStimulus(input logic [7:0] v, input bit accept, input logic [11:0] expBcd);
    value = v;
    load  = 1'b1;
    if (accept) begin
      expQ.push_back(expBcd);
      nAccepted++;
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  // Bounded wait for done; returns on the falling edge where done is seen.
  task automatic waitDone(input string name);
    for (int i = 0; i < 12; i++) begin
      if (done) return;
      @(negedge clk);
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  task automatic checkOutput(input string name, input logic expBusy, input logic expDone,
                             input logic [11:0] expBcd);
    check({name, "_busy"}, busy, expBusy);
    check({name, "_done"}, done, expDone);
    check({name, "_bcd"},  bcd,  expBcd);
  endtask

  // Observes one full refresh period after the display has settled and
  // checks digit order, per-digit dwell and the segment pattern of each digit.
  task automatic checkScan(input logic [7:0] v, input bit raw);
    logic [3:0] d[3];
    logic [6:0] expSeg[3];
    int         cnt[3];
    int         idx;
    int         prev;
    logic [3:0] a;
    logic [6:0] s;
    d[0] = 4'(v % 10);
    d[1] = 4'((v / 10) % 10);
    d[2] = 4'(v / 100);
    for (int k = 0; k < 3; k++) expSeg[k] = segTable[d[k]];
    if (!raw) begin
      if (d[2] == 4'd0) expSeg[2] = 7'b1111111;
      if (d[2] == 4'd0 && d[1] == 4'd0) expSeg[1] = 7'b1111111;
    end
    cnt  = '{0, 0, 0};
    prev = -1;
    repeat (3 * SCAN_DIV + 2) @(negedge clk);
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      @(negedge clk);
      a = raw ? an0 : an;
      s = raw ? seg0 : seg;
      case (a)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        default: idx = 3;
      endcase
      if (idx == 3) begin
        check("scan_an_onehot", a, 4'b1110);
      end else begin
        cnt[idx]++;
        check(raw ? "scan_seg_raw" : "scan_seg", s, expSeg[idx]);
        if (prev >= 0 && idx != prev) check("scan_order", idx, (prev + 1) % 3);
        prev = idx;
      end
    end
    for (int k = 0; k < 3; k++) check("scan_dwell", cnt[k], SCAN_DIV);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding load.
  always @(negedge clk) begin
    if (done) begin
      nDone++;
      if (expQ.size() == 0) begin
        check("done_without_load", expQ.size(), 1);
      end else begin
        monExp = expQ.pop_front();
        check("bcd_on_done", bcd, monExp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneBefore;

    vecs[0] = '{8'd0,   12'h000};
    vecs[1] = '{8'd9,   12'h009};
    vecs[2] = '{8'd10,  12'h010};
    vecs[3] = '{8'd99,  12'h099};
    vecs[4] = '{8'd100, 12'h100};
    vecs[5] = '{8'd128, 12'h128};
    vecs[6] = '{8'd199, 12'h199};
    vecs[7] = '{8'd200, 12'h200};
    vecs[8] = '{8'd254, 12'h254};
    vecs[9] = '{8'd255, 12'h255};

    // Reset held for three clocks with load asserted.
    reset = 1'b0;
    load  = 1'b1;
    value = 8'd55;
    repeat (3) @(negedge clk);
    checkOutput("reset", 1'b0, 1'b0, 12'h000);
    check("reset_an",  an,  4'b1110);
    check("reset_seg", seg, 7'b1000000);
    load  = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset", 1'b0, 1'b0, 12'h000);

    // Full-scale value: exact busy/done timing, then scan contents.
    applyStimulus(8'd255, 1'b1, 12'h255);
    check("fs_busy_accept", busy, 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check("fs_busy_conv", busy, 1);
      check("fs_done_early", done, 0);
    end
    @(negedge clk);
    checkOutput("fs_complete", 1'b0, 1'b1, 12'h255);
    @(negedge clk);
    check("fs_done_single", done, 0);
    checkScan(8'd255, 1'b0);

    // Leading-zero blanking on both instances.
    applyStimulus(8'd7, 1'b1, 12'h007);
    waitDone("done_7");
    check("raw_bcd_7", bcd0, 12'h007);
    checkScan(8'd7, 1'b0);
    checkScan(8'd7, 1'b1);

    // Load while busy is ignored; load in the done cycle is accepted.
    applyStimulus(8'd200, 1'b1, 12'h200);
    repeat (2) @(negedge clk);
    applyStimulus(8'd99, 1'b0, 12'h000);
    waitDone("done_200");
    check("busy_load_bcd", bcd, 12'h200);
    applyStimulus(8'd99, 1'b1, 12'h099);
    repeat (8) @(negedge clk);
    checkOutput("done_cycle_load", 1'b0, 1'b1, 12'h099);

    // Reset on the fourth conversion clock aborts without a done pulse.
    @(negedge clk);
    applyStimulus(8'd128, 1'b0, 12'h000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort", 1'b0, 1'b0, 12'h000);
    check("abort_an",  an,  4'b1110);
    check("abort_seg", seg, 7'b1000000);
    reset = 1'b1;
    doneBefore = nDone;
    repeat (12) @(negedge clk);
    check("abort_no_done", nDone, doneBefore);
    check("abort_bcd_held", bcd, 12'h000);

    // Table vectors, back-to-back.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].value, 1'b1, vecs[i].expBcd);
      waitDone("table");
    end

    // Full sweep at maximum throughput: next load lands in each done cycle.
    for (int v = 0; v < 256; v++) begin
      applyStimulus(8'(v), 1'b1, toBcd(v));
      waitDone("sweep");
    end
    @(negedge clk);
    check("queue_empty", expQ.size(), 0);
    check("done_count", nDone, nAccepted);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/result_display_8bit.md
# result_display_8bit

Downstream display stage for the 8-bit token calculator. It captures each finished 8-bit unsigned result on a load strobe and converts it to three BCD digits with a sequential double-dabble engine, one shift per clock. It then drives a time-multiplexed, active-low 7-segment display, with optional leading-zero blanking. The display always shows the last completed conversion, so the digits stay stable while a new conversion runs.

## Interface
- `SCAN_DIV`, default 16: clocks per displayed digit (≥2).
- `BLANK_LEADING`, default 1: 1 blanks leading zeros in the hundreds and tens positions.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: reset, synchronous, active-low; clock clk.
- `value` in 8: unsigned result to display; sampled only on an accepted load.
- `load` in 1: request to convert `value`; accepted only while idle.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse when `bcd` has just been updated.
- `bcd` out 12: last completed result as {hundreds, tens, units}, 4 bits each.
- `seg` out 7: active-low segments, {g,f,e,d,c,b,a}.
- `an` out 4: active-low digit enables; `an[0]` = units, `an[1]` = tens, `an[2]` = hundreds, `an[3]` tied to 1.

## Operation
- **Converter FSM states:**
  - IDLE to CONV when `load`=1: `value` goes into the shift register, scratch BCD is cleared, shift count = 0.
  - CONV runs 8 iterations. Each iteration adds 3 to every scratch BCD nibble ≥5, then shifts {scratch, shift register} left by 1.
  - After the 8th iteration the FSM returns to IDLE. It writes the final scratch value to `bcd` and pulses `done`.
- **Load rules:**
  - `load` is ignored in CONV; there is no queue.
  - `load` sampled in the cycle `done` is high is accepted, because the FSM is already IDLE.
- **Width rules:**
  - Scratch is 12 bits. The hundreds digit never exceeds 2, so the correction never overflows.
  - Input 0..255 maps to 000..255 exactly.
- **Scan:**
  - A free-running divider counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the divider wraps and the digit index advances 0, 1, 2, 0 (units, tens, hundreds).
  - `an` is one-hot low on the current index.
- **Segment decode**, BCD to `seg`:
  - 0 → 1000000
  - 1 → 1111001
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
  - blank or 10-15 → 1111111
- **Blanking** (BLANK_LEADING=1):
  - Hundreds is blank when it is 0.
  - Tens is blank when hundreds = 0 and tens = 0.
  - Units is never blank.
  - With BLANK_LEADING=0 every digit is decoded.
- **Reset** (`reset`=0 at an edge):
  - Applies in any state, including mid-conversion.
  - FSM goes to IDLE; `busy`=0, `done`=0, `bcd`=12'h000.
  - Divider and digit index go to 0, so `an`=4'b1110 and `seg`=1000000.
  - An aborted conversion produces no `done`.

## Timing
- **Load accepted at edge k:** `busy`=1 from after edge k.
- **Shifts:** edges k+1..k+8 perform the 8 shifts.
- **Completion, after edge k+8:** `bcd` is valid, `done`=1 for exactly one cycle, `busy`=0.
- **Latency:** 8 clocks from accept to `done`.
- **Throughput:** minimum 9 clocks between accepted loads.
- **Output registers:** `busy`, `done`, `bcd`, `an` and `seg` are all registered, with no combinational path from `value` or `load`.
- **Display update:** `seg` reflects the new `bcd` starting at the next scan step. It shows the old value until then, and never a partial conversion.
- **Scan period:** each digit holds for SCAN_DIV clocks; the full refresh is 3·SCAN_DIV clocks.
- **Simultaneous events:** `load`=1 together with `reset`=0 means reset wins and the load is dropped.

## Test plan
- **Reset:** hold `reset`=0 for 3 clocks → `busy`=0, `done`=0, `bcd`=000, `an`=1110, `seg`=1000000; `load` during reset has no effect.
- **Full-scale value:** `value`=255, `load` for 1 clock → `busy` high for 8 clocks, `done` pulse 8 clocks after accept, `bcd`=12'h255. Scan shows:
  - `an`=1110 with `seg`=0010010
  - `an`=1101 with `seg`=0010010
  - `an`=1011 with `seg`=0100100
  - each for SCAN_DIV clocks.
- **Leading-zero blanking:** `value`=7 → `bcd`=12'h007.
  - BLANK_LEADING=1: units `seg`=1111000, tens and hundreds `seg`=1111111.
  - BLANK_LEADING=0: tens and hundreds `seg`=1000000.
- **Load while busy:**
  - Load 200, then load 99 three clocks later → second load ignored, `bcd`=12'h200.
  - Then load 99 in the `done` cycle → accepted, `bcd`=12'h099 9 clocks later.
- **Reset mid-conversion:** load 128, assert `reset` at the 4th CONV clock → `busy`=0 next cycle, no `done` ever, `bcd`=000.
- **Sweep:** every value 0..255, back-to-back at maximum throughput → each `bcd` equals the decimal value, exactly one `done` per load.
